// File: rtl/ldm_stm_sequencer_if.sv
// ldm_stm_sequencer_if: launch/stall inputs plus register-file and memory beat outputs of the sequencer
interface ldm_stm_sequencer_if #(parameter int NLIST = 16, parameter int AW = 32, parameter int RA_W = 32);
  logic start;
  logic [NLIST-1:0] reglist;
  logic [AW-1:0] base;
  logic [3:0] baseidx;
  logic load, up, pre, wback, stall;
  logic busy;
  logic [RA_W-1:0] ra, wa;
  logic we, mem_req, mem_we;
  logic [AW-1:0] mem_addr, base_wb_val;
  logic done;
  modport master (
    output start, reglist, base, baseidx, load, up, pre, wback, stall,
    input busy, ra, wa, we, mem_req, mem_we, mem_addr, base_wb_val, done
  );
  modport slave (
    input start, reglist, base, baseidx, load, up, pre, wback, stall,
    output busy, ra, wa, we, mem_req, mem_we, mem_addr, base_wb_val, done
  );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer: LDM/STM block-transfer micro-sequencer (define LDM_EMPTY_LIST_EN for the ARMv4 empty-list rule)
module ldm_stm_sequencer #(
  parameter int NLIST = 16,
  parameter int AW    = 32,
  parameter int RA_W  = 32
) (
  input logic clk,
  input logic reset,
  ldm_stm_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
  state_t state, state_nx;
  logic [NLIST-1:0] list, eff, oh, rest;
  logic [AW-1:0] addr, wb_val, size, start_addr;
  logic [3:0] bidx;
  logic ld, wb_en, wb_en_nx;
  always_comb begin
`ifdef LDM_EMPTY_LIST_EN
    eff = (bus.reglist == '0) ? {1'b1, {(NLIST-1){1'b0}}} : bus.reglist;
    size = (bus.reglist == '0) ? AW'(64) : AW'($countones(bus.reglist)) << 2;
`else
    eff = bus.reglist;
    size = AW'($countones(bus.reglist)) << 2;
`endif
    start_addr = bus.up ? bus.base + (bus.pre ? AW'(4) : '0) : bus.base - size + (bus.pre ? '0 : AW'(4));
    // A loaded base register overrides the writeback value
    wb_en_nx = bus.wback && !(bus.load && eff[bus.baseidx]);
    oh = list & (~list + NLIST'(1));
    rest = list & ~oh;
    state_nx = (state == IDLE) ? (bus.start ? ((eff != '0) ? XFER : DONE) : IDLE) :
               (state == XFER) ? ((!bus.stall && rest == '0) ? DONE : XFER) : IDLE;
    bus.busy = state != IDLE;
    bus.done = state == DONE;
    bus.mem_req = state == XFER;
    bus.mem_we = (state == XFER) && !ld;
    bus.mem_addr = (state == XFER) ? addr : '0;
    bus.ra = ((state == XFER) && !ld) ? RA_W'(oh) : '0;
    bus.wa = ((state == XFER) && ld) ? RA_W'(oh) : ((state == DONE) && wb_en) ? RA_W'(1) << bidx : '0;
    bus.we = ((state == XFER) && ld) || ((state == DONE) && wb_en);
    bus.base_wb_val = wb_val;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      list <= '0;
      addr <= '0;
      wb_val <= '0;
      bidx <= '0;
      ld <= 1'b0;
      wb_en <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.start) begin
        list <= eff;
        addr <= start_addr;
        wb_val <= bus.up ? bus.base + size : bus.base - size;
        bidx <= bus.baseidx;
        ld <= bus.load;
        wb_en <= wb_en_nx;
      end else if (state == XFER && !bus.stall) begin
        list <= rest;
        addr <= addr + AW'(4);
      end
    end
  end
endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// tb_ldm_stm_sequencer: directed and randomized checks of the sequencer against a list/address model
module tb_ldm_stm_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  ldm_stm_sequencer_if bus ();
  ldm_stm_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic run_op(input string name, input logic [15:0] rl, input logic [31:0] b, input logic [3:0] bi,
                        input logic ld, input logic u, input logic p, input logic w,
                        input int stall_beat, input int stall_len, input int rnd_pct);
    logic [15:0] eff;
    logic [31:0] sz, lo, wbv;
    logic wbe;
    int ks[$];
    int st;
    logic [100:0] got, exp;
    eff = rl;
    sz = 32'(4 * $countones(rl));
`ifdef LDM_EMPTY_LIST_EN
    if (rl == 16'h0) begin
      eff = 16'h8000;
      sz = 32'h40;
    end
`endif
    lo = u ? b + (p ? 32'd4 : 32'd0) : b - sz + (p ? 32'd0 : 32'd4);
    wbv = u ? b + sz : b - sz;
    wbe = w && !(ld && eff[bi]);
    for (int i = 0; i < 16; i++) if (eff[i]) ks.push_back(i);
    bus.start = 1'b1; bus.reglist = rl; bus.base = b; bus.baseidx = bi;
    bus.load = ld; bus.up = u; bus.pre = p; bus.wback = w; bus.stall = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    foreach (ks[i]) begin
      st = (i == stall_beat) ? stall_len : (int'($urandom_range(99)) < rnd_pct ? int'($urandom_range(3, 1)) : 0);
      for (int s = 0; s <= st; s++) begin
        exp = {1'b1, 1'b0, 1'b1, !ld, ld, ld ? 32'd0 : (32'd1 << ks[i]), ld ? (32'd1 << ks[i]) : 32'd0, lo + 32'(4 * i)};
        got = {bus.busy, bus.done, bus.mem_req, bus.mem_we, bus.we, bus.ra, bus.wa, bus.mem_addr};
        n_cmp++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL %s beat%0d hold%0d: got %h expected %h", name, i, s, got, exp);
        end
        bus.stall = s < st;
        if (rnd_pct > 0) begin
          bus.start = 1'($urandom); bus.reglist = 16'($urandom); bus.base = $urandom;
          bus.baseidx = 4'($urandom); bus.load = 1'($urandom); bus.up = 1'($urandom);
          bus.pre = 1'($urandom); bus.wback = 1'($urandom);
        end
        @(negedge clk);
      end
    end
    exp = {1'b1, 1'b1, 1'b0, 1'b0, wbe, 32'd0, wbe ? (32'd1 << bi) : 32'd0, 32'd0};
    got = {bus.busy, bus.done, bus.mem_req, bus.mem_we, bus.we, bus.ra, bus.wa, bus.mem_addr};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s done: got %h expected %h", name, got, exp);
    end
    n_cmp++;
    if (bus.base_wb_val !== wbv) begin
      n_bad++;
      $display("FAIL %s base_wb_val: got %h expected %h", name, bus.base_wb_val, wbv);
    end
    bus.start = 1'b0;
    bus.stall = 1'($urandom);
    @(negedge clk);
    bus.stall = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.done, bus.mem_req, bus.we} !== 4'b0) begin
      n_bad++;
      $display("FAIL %s idle: got %b expected 0000", name, {bus.busy, bus.done, bus.mem_req, bus.we});
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b1; bus.reglist = 16'hFFFF; bus.base = 32'h1234; bus.baseidx = 4'd3;
    bus.load = 1'b1; bus.up = 1'b1; bus.pre = 1'b0; bus.wback = 1'b1; bus.stall = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.done, bus.mem_req, bus.mem_we, bus.we, bus.ra, bus.wa, bus.mem_addr, bus.base_wb_val} !== '0) begin
      n_bad++;
      $display("FAIL reset: got busy=%b done=%b req=%b we=%b ra=%h wa=%h addr=%h wb=%h expected all 0",
               bus.busy, bus.done, bus.mem_req, bus.we, bus.ra, bus.wa, bus.mem_addr, bus.base_wb_val);
    end
    bus.start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: got busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_stm_ia();
    run_op("stm_ia", 16'h000E, 32'h1000, 4'd4, 1'b0, 1'b1, 1'b0, 1'b1, -1, 0, 0);
  endtask

  task automatic test_ldm_db();
    run_op("ldm_db", 16'h8001, 32'h2000, 4'd7, 1'b1, 1'b0, 1'b1, 1'b1, -1, 0, 0);
  endtask

  task automatic test_stall();
    run_op("ldm_ib_stall", 16'h0030, 32'h100, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1, 2, 0);
  endtask

  task automatic test_base_in_list();
    run_op("ldm_base_in_list", 16'h0011, 32'h500, 4'd4, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0, 0);
  endtask

  task automatic test_abort();
    bus.start = 1'b1; bus.reglist = 16'h00FF; bus.base = 32'h4000; bus.baseidx = 4'd9;
    bus.load = 1'b0; bus.up = 1'b1; bus.pre = 1'b0; bus.wback = 1'b1; bus.stall = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_req, bus.mem_addr, bus.ra} !== {1'b1, 32'h4004, 32'h2}) begin
      n_bad++;
      $display("FAIL abort_beat2: got req=%b addr=%h ra=%h expected 1/4004/2", bus.mem_req, bus.mem_addr, bus.ra);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.mem_req, bus.done, bus.we} !== 4'b0) begin
      n_bad++;
      $display("FAIL abort_reset: got %b expected 0000", {bus.busy, bus.mem_req, bus.done, bus.we});
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.done, bus.mem_req} !== 2'b0) begin
        n_bad++;
        $display("FAIL abort_quiet%0d: got done/req %b expected 00", i, {bus.done, bus.mem_req});
      end
    end
    run_op("after_abort", 16'h0006, 32'h4000, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 0);
  endtask

  task automatic test_empty();
    run_op("empty_list", 16'h0000, 32'h3000, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++)
      run_op("random", ($urandom_range(7) == 0) ? 16'h0 : 16'($urandom), $urandom, 4'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), -1, 0, 30);
  endtask

  initial begin
    test_reset();
    test_stm_ia();
    test_ldm_db();
    test_stall();
    test_base_in_list();
    test_abort();
    test_empty();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
